// File: rtl/dct_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dct_block_sequencer                                                        |
// | Feeds an 8x8 pixel block row-wise into the 1D DCT row engine, gathers the  |
// | results in a transpose buffer and streams the block out column-wise.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dct_block_sequencer #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic [63:0] i_pix_row,
  output logic        o_dct_valid,
  output logic [63:0] o_dct_row,
  input  logic        i_dct_valid,
  input  logic [95:0] i_dct_row,
  output logic        o_col_valid,
  input  logic        i_col_ready,
  output logic [95:0] o_col_data,
  output logic [2:0]  o_col_idx,
  output logic        o_col_last,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_FEED  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [63:0] c_sign_mask = {8{8'h80}};

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_in_cnt, w_in_cnt_nxt;
  logic [3:0]       r_res_cnt, w_res_cnt_nxt;
  logic [2:0]       r_col_cnt, w_col_cnt_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic             r_pix_ready;
  logic             r_dct_valid;
  logic [63:0]      r_dct_row;
  logic             r_err;
  logic [95:0]      r_buf [8];
  logic [95:0]      w_col_data;
  logic             w_accept, w_capture, w_spurious, w_col_hs, w_timeout;

  assign w_accept    = i_pix_valid & r_pix_ready;
  assign w_capture   = i_dct_valid & (r_state != S_DRAIN) & (r_res_cnt < r_in_cnt);
  assign w_spurious  = i_dct_valid & ~w_capture;
  assign w_col_hs    = (r_state == S_DRAIN) & i_col_ready;
  assign w_timer_inc = r_timer + CNT_W'(1);
  // The timer is held during the issue cycle of row 7 so counting starts one cycle later.
  assign w_timeout   = (r_state == S_WAIT) & ~r_dct_valid & (w_timer_inc == CNT_W'(TIMEOUT))
                     & (w_res_cnt_nxt != 4'd8);

  always_comb begin
    w_state_nxt   = r_state;
    w_in_cnt_nxt  = r_in_cnt;
    w_res_cnt_nxt = r_res_cnt;
    w_col_cnt_nxt = r_col_cnt;
    w_timer_nxt   = r_timer;
    if (w_accept)  w_in_cnt_nxt  = r_in_cnt + 4'd1;
    if (w_capture) w_res_cnt_nxt = r_res_cnt + 4'd1;
    case (r_state)
      S_FEED: begin
        if (w_accept && (r_in_cnt == 4'd7)) begin
          w_state_nxt = S_WAIT;
          w_timer_nxt = '0;
        end
      end
      S_WAIT: begin
        if (!r_dct_valid) w_timer_nxt = w_timer_inc;
        if (w_res_cnt_nxt == 4'd8) begin
          w_state_nxt = S_DRAIN;
          w_timer_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt   = S_FEED;
          w_in_cnt_nxt  = '0;
          w_res_cnt_nxt = '0;
          w_timer_nxt   = '0;
        end
      end
      S_DRAIN: begin
        if (w_col_hs) begin
          w_col_cnt_nxt = r_col_cnt + 3'd1;
          if (r_col_cnt == 3'd7) begin
            w_state_nxt   = S_FEED;
            w_in_cnt_nxt  = '0;
            w_res_cnt_nxt = '0;
            w_col_cnt_nxt = '0;
            w_timer_nxt   = '0;
          end
        end
      end
      default: w_state_nxt = S_FEED;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_FEED;
      r_in_cnt    <= '0;
      r_res_cnt   <= '0;
      r_col_cnt   <= '0;
      r_timer     <= '0;
      r_pix_ready <= 1'b0;
      r_dct_valid <= 1'b0;
      r_dct_row   <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_cnt    <= w_in_cnt_nxt;
      r_res_cnt   <= w_res_cnt_nxt;
      r_col_cnt   <= w_col_cnt_nxt;
      r_timer     <= w_timer_nxt;
      r_pix_ready <= (w_state_nxt == S_FEED) && (w_in_cnt_nxt < 4'd8);
      r_dct_valid <= w_accept;
      if (w_accept)                r_dct_row <= i_pix_row ^ c_sign_mask;
      if (w_capture)               r_buf[r_res_cnt[2:0]] <= i_dct_row;
      if (w_spurious || w_timeout) r_err <= 1'b1;
    end
  end

  // Transpose read: element r of the column comes from result row r.
  always_comb begin
    w_col_data = '0;
    for (int r = 0; r < 8; r++) w_col_data[12*r +: 12] = r_buf[r][12*r_col_cnt +: 12];
  end

  assign o_pix_ready = r_pix_ready;
  assign o_dct_valid = r_dct_valid;
  assign o_dct_row   = r_dct_row;
  assign o_col_valid = (r_state == S_DRAIN);
  assign o_col_data  = w_col_data;
  assign o_col_idx   = r_col_cnt;
  assign o_col_last  = (r_state == S_DRAIN) && (r_col_cnt == 3'd7);
  assign o_busy      = (r_state != S_FEED) || (r_in_cnt != 4'd0);
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dct_block_sequencer.sv
`default_nettype none
// Directed bench for dct_block_sequencer with a fixed-latency echo model of the row engine.
module tb_dct_block_sequencer;
  localparam int LAT = 13;

  logic        clk;
  logic        rst;
  logic        i_pix_valid;
  logic        o_pix_ready;
  logic [63:0] i_pix_row;
  logic        o_dct_valid;
  logic [63:0] o_dct_row;
  logic        i_dct_valid = 1'b0;
  logic [95:0] i_dct_row = '0;
  logic        o_col_valid;
  logic        i_col_ready;
  logic [95:0] o_col_data;
  logic [2:0]  o_col_idx;
  logic        o_col_last;
  logic        o_busy;
  logic        o_err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  blk [8][8];
  logic [63:0] issued_q[$];
  logic [95:0] cols_got [8];
  logic [2:0]  idx_got [8];
  logic        last_got [8];
  int          ncols, stab_bad, pr_bad;

  logic        pipe_v [LAT];
  logic [63:0] pipe_d [LAT];
  logic [2:0]  eng_cnt = '0;
  logic        eng_drop5 = 1'b0;
  logic        eng_extra = 1'b0;

  dct_block_sequencer #(.TIMEOUT(32), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_pix_row(i_pix_row),
    .o_dct_valid(o_dct_valid), .o_dct_row(o_dct_row),
    .i_dct_valid(i_dct_valid), .i_dct_row(i_dct_row),
    .o_col_valid(o_col_valid), .i_col_ready(i_col_ready), .o_col_data(o_col_data),
    .o_col_idx(o_col_idx), .o_col_last(o_col_last),
    .o_busy(o_busy), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack_row(input int r);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = blk[r][k];
    return v;
  endfunction

  function automatic logic [95:0] sext_row(input logic [63:0] d);
    logic [95:0] v;
    logic [7:0]  b;
    for (int k = 0; k < 8; k++) begin
      b = d[8*k +: 8];
      v[12*k +: 12] = {{4{b[7]}}, b};
    end
    return v;
  endfunction

  function automatic logic [95:0] exp_col(input int c);
    logic [95:0] v;
    logic [7:0]  b;
    for (int r = 0; r < 8; r++) begin
      b = blk[r][c] ^ 8'h80;
      v[12*r +: 12] = {{4{b[7]}}, b};
    end
    return v;
  endfunction

  // Engine model: echoes each issued row sign-extended, LAT cycles later.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        pipe_v[k] = 1'b0;
        pipe_d[k] = '0;
      end
      eng_cnt     = '0;
      i_dct_valid = 1'b0;
      i_dct_row   = '0;
    end else begin
      i_dct_valid = pipe_v[LAT-1] | eng_extra;
      i_dct_row   = sext_row(pipe_d[LAT-1]);
      for (int k = LAT-1; k > 0; k--) begin
        pipe_v[k] = pipe_v[k-1];
        pipe_d[k] = pipe_d[k-1];
      end
      pipe_v[0] = o_dct_valid & ~(eng_drop5 & (eng_cnt == 3'd5));
      pipe_d[0] = o_dct_row;
      if (o_dct_valid) eng_cnt = eng_cnt + 3'd1;
    end
  end

  always @(negedge clk) if (o_dct_valid) issued_q.push_back(o_dct_row);

  task automatic set_ramp(input int base);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) blk[r][k] = 8'((base + 16*r + k) % 256);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_pix_valid = 1'b0; i_col_ready = 1'b0; eng_drop5 = 1'b0; eng_extra = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issued_q.delete();
  endtask

  task automatic feed_rows(input int first, input int gap);
    int t;
    for (int r = first; r < 8; r++) begin
      repeat (gap) @(negedge clk);
      i_pix_row = pack_row(r);
      i_pix_valid = 1'b1;
      t = 0;
      while (!o_pix_ready && t < 300) begin @(negedge clk); t++; end
      if (t >= 300) begin
        checks++; errors++;
        $display("FAIL feed_wait row %0d: o_pix_ready=0, required 1", r);
      end
      @(negedge clk);
      i_pix_valid = 1'b0;
    end
  endtask

  task automatic collect_cols(input logic [3:0] pat, input int max_cyc);
    int cyc;
    logic hold;
    logic [95:0] pd;
    logic [2:0] pi;
    ncols = 0; stab_bad = 0; pr_bad = 0; hold = 1'b0; cyc = 0; pd = '0; pi = '0;
    while (ncols < 8 && cyc < max_cyc) begin
      i_col_ready = pat[cyc % 4];
      if (hold && (!o_col_valid || o_col_data !== pd || o_col_idx !== pi)) stab_bad++;
      if (o_col_valid && o_pix_ready) pr_bad++;
      if (o_col_valid && i_col_ready) begin
        cols_got[ncols] = o_col_data;
        idx_got[ncols]  = o_col_idx;
        last_got[ncols] = o_col_last;
        ncols++;
        hold = 1'b0;
      end else begin
        hold = o_col_valid;
        pd = o_col_data;
        pi = o_col_idx;
      end
      @(negedge clk);
      cyc++;
    end
    i_col_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_pix_valid = 1'b0; i_pix_row = '0; i_col_ready = 1'b0;
    @(negedge clk);
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready: got %b want 0", o_pix_ready); end
    checks++; if (o_dct_valid !== 1'b0) begin errors++; $display("FAIL rst_dct_valid: got %b want 0", o_dct_valid); end
    checks++; if (o_dct_row !== 64'h0) begin errors++; $display("FAIL rst_dct_row: got %h want 0", o_dct_row); end
    checks++; if (o_col_valid !== 1'b0 || o_col_last !== 1'b0) begin errors++; $display("FAIL rst_col: valid=%b last=%b want 0", o_col_valid, o_col_last); end
    checks++; if (o_col_data !== 96'h0 || o_col_idx !== 3'd0) begin errors++; $display("FAIL rst_col_data: got %h idx %0d want 0", o_col_data, o_col_idx); end
    checks++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL rst_status: busy=%b err=%b want 0", o_busy, o_err); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_before_edge: got %b want 0", o_pix_ready); end
    @(negedge clk);
    checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_edge: got %b want 1", o_pix_ready); end
    issued_q.delete();
  endtask

  task automatic test_single_block();
    set_ramp(0);
    issued_q.delete();
    feed_rows(0, 0);
    checks++; if (o_pix_ready !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL sb_after_feed: ready=%b busy=%b want 0/1", o_pix_ready, o_busy); end
    collect_cols(4'b1111, 200);
    checks++; if (issued_q.size() != 8) begin errors++; $display("FAIL sb_issue_count: got %0d want 8", issued_q.size()); end
    checks++; if (issued_q[0] !== 64'h8786858483828180) begin errors++; $display("FAIL sb_row0: got %h want 8786858483828180", issued_q[0]); end
    for (int r = 1; r < 8; r++) begin
      checks++; if (issued_q[r] !== (pack_row(r) ^ {8{8'h80}})) begin errors++; $display("FAIL sb_row%0d: got %h want %h", r, issued_q[r], pack_row(r) ^ {8{8'h80}}); end
    end
    checks++; if (ncols != 8) begin errors++; $display("FAIL sb_ncols: got %0d want 8", ncols); end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (cols_got[c] !== exp_col(c) || idx_got[c] !== 3'(c) || last_got[c] !== (c == 7)) begin
        errors++; $display("FAIL sb_col%0d: got %h idx %0d last %b want %h idx %0d last %b", c, cols_got[c], idx_got[c], last_got[c], exp_col(c), c, c == 7);
      end
    end
    checks++; if (cols_got[0][11:0] !== 12'hF80 || cols_got[7][95:84] !== 12'hFF7) begin errors++; $display("FAIL sb_corner: got %h/%h want F80/FF7", cols_got[0][11:0], cols_got[7][95:84]); end
    checks++; if (o_err !== 1'b0 || o_busy !== 1'b0 || o_pix_ready !== 1'b1) begin errors++; $display("FAIL sb_end: err=%b busy=%b ready=%b want 0/0/1", o_err, o_busy, o_pix_ready); end
  endtask

  task automatic test_level_shift();
    set_ramp(3);
    for (int k = 0; k < 8; k++) begin
      blk[0][k] = 8'h00; blk[1][k] = 8'h80; blk[2][k] = 8'hFF;
    end
    issued_q.delete();
    feed_rows(0, 0);
    collect_cols(4'b1111, 200);
    checks++; if (issued_q[0] !== {8{8'h80}}) begin errors++; $display("FAIL ls_00: got %h want 8080808080808080", issued_q[0]); end
    checks++; if (issued_q[1] !== 64'h0) begin errors++; $display("FAIL ls_80: got %h want 0", issued_q[1]); end
    checks++; if (issued_q[2] !== {8{8'h7F}}) begin errors++; $display("FAIL ls_FF: got %h want 7f7f7f7f7f7f7f7f", issued_q[2]); end
    checks++; if (cols_got[4][35:0] !== 36'h07F000F80) begin errors++; $display("FAIL ls_col4: got %h want 07f000f80", cols_got[4][35:0]); end
    checks++; if (cols_got[6] !== exp_col(6)) begin errors++; $display("FAIL ls_col6: got %h want %h", cols_got[6], exp_col(6)); end
  endtask

  task automatic test_backpressure();
    int extra;
    set_ramp(77);
    issued_q.delete();
    feed_rows(0, 0);
    collect_cols(4'b1001, 300);
    checks++; if (ncols != 8) begin errors++; $display("FAIL bp_ncols: got %0d want 8", ncols); end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_bad); end
    checks++; if (pr_bad != 0) begin errors++; $display("FAIL bp_pix_ready: got %0d ready cycles in drain want 0", pr_bad); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (cols_got[c] !== exp_col(c) || idx_got[c] !== 3'(c)) begin errors++; $display("FAIL bp_col%0d: got %h idx %0d want %h idx %0d", c, cols_got[c], idx_got[c], exp_col(c), c); end
    end
    extra = 0;
    i_col_ready = 1'b1;
    repeat (4) begin if (o_col_valid) extra++; @(negedge clk); end
    i_col_ready = 1'b0;
    checks++; if (extra != 0) begin errors++; $display("FAIL bp_extra_cols: got %0d want 0", extra); end
  endtask

  task automatic test_input_stalls();
    set_ramp(40);
    issued_q.delete();
    feed_rows(0, 2);
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL st_ready_drop: got %b want 0", o_pix_ready); end
    i_pix_row = pack_row(0);
    i_pix_valid = 1'b1;
    collect_cols(4'b1111, 200);
    checks++; if (issued_q.size() != 8) begin errors++; $display("FAIL st_no_9th: issued %0d want 8", issued_q.size()); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (issued_q[r] !== (pack_row(r) ^ {8{8'h80}})) begin errors++; $display("FAIL st_order%0d: got %h want %h", r, issued_q[r], pack_row(r) ^ {8{8'h80}}); end
    end
    checks++; if (ncols != 8 || cols_got[5] !== exp_col(5)) begin errors++; $display("FAIL st_cols: n=%0d col5 %h want 8 %h", ncols, cols_got[5], exp_col(5)); end
    @(negedge clk);
    i_pix_valid = 1'b0;
    @(negedge clk);
    checks++; if (issued_q.size() != 9 || issued_q[8] !== (pack_row(0) ^ {8{8'h80}})) begin errors++; $display("FAIL st_9th_after_drain: n=%0d row %h want 9", issued_q.size(), issued_q[8]); end
    feed_rows(1, 0);
    collect_cols(4'b1111, 200);
    checks++; if (ncols != 8 || cols_got[2] !== exp_col(2)) begin errors++; $display("FAIL st_next_block: n=%0d col2 %h want 8 %h", ncols, cols_got[2], exp_col(2)); end
  endtask

  task automatic test_timeout();
    int colv;
    set_ramp(9);
    eng_drop5 = 1'b1;
    issued_q.delete();
    feed_rows(0, 0);
    colv = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (o_col_valid) colv++;
      if (k == 28) begin
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL to_early: err=%b at +28 want 0", o_err); end
      end
    end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_err: err=%b at +36 want 1", o_err); end
    checks++; if (o_busy !== 1'b0 || o_pix_ready !== 1'b1) begin errors++; $display("FAIL to_feed: busy=%b ready=%b want 0/1", o_busy, o_pix_ready); end
    checks++; if (colv != 0) begin errors++; $display("FAIL to_no_cols: got %0d col cycles want 0", colv); end
    eng_drop5 = 1'b0;
  endtask

  task automatic test_drain_spurious();
    do_reset();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ds_err_clear: got %b want 0", o_err); end
    set_ramp(130);
    feed_rows(0, 0);
    fork
      collect_cols(4'b1001, 300);
      begin : inject
        int t;
        t = 0;
        while (!o_col_valid && t < 200) begin @(negedge clk); t++; end
        #1 eng_extra = 1'b1;
        @(negedge clk);
        #1 eng_extra = 1'b0;
      end
    join
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ds_err: got %b want 1", o_err); end
    checks++; if (ncols != 8) begin errors++; $display("FAIL ds_ncols: got %0d want 8", ncols); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (cols_got[c] !== exp_col(c)) begin errors++; $display("FAIL ds_col%0d: got %h want %h", c, cols_got[c], exp_col(c)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) blk[r][k] = 8'((37*r + 11*k + 5) % 256);
    feed_rows(0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (o_pix_ready !== 1'b0 || o_dct_valid !== 1'b0 || o_col_valid !== 1'b0) begin errors++; $display("FAIL ar_outputs: ready=%b dval=%b cval=%b want 0", o_pix_ready, o_dct_valid, o_col_valid); end
    checks++; if (o_busy !== 1'b0 || o_err !== 1'b0 || o_dct_row !== 64'h0) begin errors++; $display("FAIL ar_status: busy=%b err=%b row=%h want 0", o_busy, o_err, o_dct_row); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (o_pix_ready !== 1'b0) begin errors++; $display("FAIL ar_ready_pre: got %b want 0", o_pix_ready); end
    @(negedge clk);
    checks++; if (o_pix_ready !== 1'b1) begin errors++; $display("FAIL ar_ready_post: got %b want 1", o_pix_ready); end
    issued_q.delete();
    feed_rows(0, 1);
    collect_cols(4'b1111, 200);
    checks++; if (ncols != 8) begin errors++; $display("FAIL ar_ncols: got %0d want 8", ncols); end
    for (int c = 0; c < 8; c++) begin
      checks++; if (cols_got[c] !== exp_col(c)) begin errors++; $display("FAIL ar_col%0d: got %h want %h", c, cols_got[c], exp_col(c)); end
    end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ar_err: got %b want 0", o_err); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_level_shift();
    test_backpressure();
    test_input_stalls();
    test_timeout();
    test_drain_spurious();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
- Controller for the 8-point 1D DCT row engine (8 x signed 8-bit in, 8 x signed 12-bit out, fixed pipeline latency, no backpressure).
- Accepts an 8x8 block of unsigned pixels one row per handshake, level-shifts each row and issues it to the engine.
- Captures the 8 result rows into an internal 8x8x12 transpose buffer, then streams the block out column by column with valid/ready backpressure.
- Sits between the pixel line buffer and the column-pass stage.

Parameters:
TIMEOUT, 32, max cycles allowed after the last row is issued before all 8 results must have returned
CNT_W, 6, width of the timeout counter; must hold TIMEOUT

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_pix_valid  in  1  pixel row valid
o_pix_ready  out  1  sequencer can accept a pixel row
i_pix_row  in  64  8 unsigned pixels; pixel k at [8k+7:8k]
o_dct_valid  out  1  row issued to engine (engine i_valid)
o_dct_row  out  64  level-shifted signed pixels, same packing
i_dct_valid  in  1  engine result valid (engine o_valid)
i_dct_row  in  96  8 signed 12-bit coefficients; coefficient k at [12k+11:12k]
o_col_valid  out  1  transposed column valid
i_col_ready  in  1  downstream accepts column
o_col_data  out  96  column c: element r (result row r) at [12r+11:12r]
o_col_idx  out  3  column index c
o_col_last  out  1  high with column 7
o_busy  out  1  block in progress
o_err  out  1  sticky error flag

Behaviour:
- Reset (async, i_rst=1): state FEED, in_cnt=res_cnt=col_cnt=0, timer=0, buffer cleared. All outputs 0, including o_pix_ready. o_pix_ready is a register: it rises on the first clock edge after reset release.
- States: FEED, WAIT, DRAIN.

FEED:
- o_pix_ready=1 while in_cnt<8; row accepted on i_pix_valid & o_pix_ready.
- For each accepted row, next cycle: o_dct_valid=1 and o_dct_row = i_pix_row with the MSB of every byte inverted (pixel-128). Otherwise o_dct_valid=0 and o_dct_row holds its last value.
- o_pix_ready deasserts on the same edge that accepts row 7 (in_cnt 7->8); no 9th row is ever accepted. Then state goes to WAIT.
- Gaps in i_pix_valid are allowed; rows are issued in acceptance order.

Result capture (FEED and WAIT):
- When i_dct_valid and res_cnt<in_cnt: write i_dct_row into buffer row res_cnt, then res_cnt++.
- When i_dct_valid and res_cnt>=in_cnt (spurious): discard, set o_err.
- In DRAIN, any i_dct_valid is discarded and sets o_err.

WAIT:
- timer counts from 0 starting the cycle after row 7 is issued.
- If res_cnt reaches 8: go to DRAIN, clear timer.
- If timer reaches TIMEOUT with res_cnt<8: set o_err, discard the block, go to FEED with counters cleared.
- Results arriving already in FEED are normal, since engine latency may be shorter or longer than 8 cycles.

DRAIN:
- o_col_valid=1; o_col_idx=col_cnt; o_col_data is a combinational mux from the buffer: element r = buffer[r][col_cnt].
- o_col_last = (col_cnt==7).
- Outputs are held stable while o_col_valid & !i_col_ready.
- On handshake, col_cnt++. On handshake of column 7: go to FEED, clear all counters, o_col_valid=0. o_pix_ready rises on that same edge.

Status and reset:
- o_busy = (state!=FEED) | (in_cnt!=0).
- o_err stays set until reset.
- Reset mid-block aborts everything immediately. Buffer contents and pending results are lost. Engine results arriving after reset release with in_cnt=0 count as spurious (o_err=1).

Test Plan:
- Single block: pixel[r][k]=16r+k. Bench engine echoes each row sign-extended after 13 cycles, i_col_ready=1.
  -> o_dct_row row0 = 0x87..80 (0x80 at [7:0], 0x87 at [63:56]).
  -> 8 columns; column c element r = sign-ext(16r+c-128); o_col_last only on c=7; o_err=0.
- Level-shift extremes: rows of 0x00, 0x80, 0xFF -> issued bytes 0x80, 0x00, 0x7F.
- Backpressure: i_col_ready toggles 1-0-0-1.
  -> o_col_data/o_col_idx stable during low cycles; exactly 8 column transfers; o_pix_ready=0 until column 7 accepted.
- Input stalls: i_pix_valid asserted every 3rd cycle -> 8 rows issued in order, ready drops after row 7; 9th presented row not accepted until drain completes.
- Errors, each case checked separately:
  -> Engine withholds row 5 result: o_err=1 at TIMEOUT=32 cycles after the last issue; return to FEED with no columns output.
  -> Extra i_dct_valid in DRAIN: o_err=1, columns unchanged.
- Async reset asserted mid-WAIT (between clock edges) -> all outputs 0 immediately; o_pix_ready=1 one edge after release; next block processes correctly.
